// File: rtl/gate_level_full_adder.sv
// One-bit full adder built from 2-input NAND cells only.
// Outputs the sum (l), the carry (h), and the lookahead terms p = a|b and g = a&b.
// REGISTER_OUT selects a registered stage with 1-cycle latency or a purely
// combinational cell. The combinational form is used inside ripple chains.
module gate_level_full_adder #(
    parameter bit REGISTER_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic l,
    output logic h,
    output logic p,
    output logic g,
    output logic out_valid
);

    // NAND network. n_ab feeds the first XOR, the carry and the generate term.
    wire n_ab;
    wire a_n1;
    wire b_n1;
    wire s1;
    wire n_sc;
    wire s1_n2;
    wire c_n2;
    wire sum_c;
    wire carry_c;
    wire gen_c;
    wire a_inv;
    wire b_inv;
    wire prop_c;

    // s1 = a xor b
    nand g_nab  (n_ab,  a,     b);
    nand g_xa   (a_n1,  a,     n_ab);
    nand g_xb   (b_n1,  b,     n_ab);
    nand g_s1   (s1,    a_n1,  b_n1);

    // l = s1 xor c
    nand g_nsc  (n_sc,  s1,    c);
    nand g_x2s  (s1_n2, s1,    n_sc);
    nand g_x2c  (c_n2,  c,     n_sc);
    nand g_sum  (sum_c, s1_n2, c_n2);

    // h = (a&b) | (s1&c)
    nand g_cry  (carry_c, n_ab, n_sc);

    // g = not(nand(a,b)); p = nand(not a, not b)
    nand g_gen  (gen_c, n_ab,  n_ab);
    nand g_ainv (a_inv, a,     a);
    nand g_binv (b_inv, b,     b);
    nand g_prop (prop_c, a_inv, b_inv);

    if (REGISTER_OUT) begin : g_reg
        logic l_q, l_d;
        logic h_q, h_d;
        logic p_q, p_d;
        logic g_q, g_d;
        logic out_valid_q;

        // Load a new result only on valid input. Otherwise the last result is held.
        always_comb begin
            l_d = l_q;
            h_d = h_q;
            p_d = p_q;
            g_d = g_q;
            if (in_valid) begin
                l_d = sum_c;
                h_d = carry_c;
                p_d = prop_c;
                g_d = gen_c;
            end
        end

        // Output register. A synchronous reset clears the outputs and drops any input in the same cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                l_q         <= 1'b0;
                h_q         <= 1'b0;
                p_q         <= 1'b0;
                g_q         <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                l_q         <= l_d;
                h_q         <= h_d;
                p_q         <= p_d;
                g_q         <= g_d;
                out_valid_q <= in_valid;
            end
        end

        assign l         = l_q;
        assign h         = h_q;
        assign p         = p_q;
        assign g         = g_q;
        assign out_valid = out_valid_q;
    end else begin : g_comb
        // The clock has no effect on a combinational cell.
        wire unused_clk;
        wire rst_n;
        assign unused_clk = clk;

        assign l = sum_c;
        assign h = carry_c;
        assign p = prop_c;
        assign g = gen_c;

        // out_valid = in_valid & ~rst, built from NAND cells.
        nand g_rstn (rst_n, rst, rst);
        wire ov_n;
        nand g_ovn  (ov_n, in_valid, rst_n);
        nand g_ov   (out_valid, ov_n, ov_n);
    end

endmodule

// File: tb/tb_gate_level_full_adder.sv
// Testbench for gate_level_full_adder.
// Checks the registered cell against a behavioural reference through an
// expected-result queue. Also checks a two-bit ripple chain built from the
// combinational form.
module tb_gate_level_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;
    logic l, h, p, g, out_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_level_full_adder #(.REGISTER_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b), .c(c),
        .l(l), .h(h), .p(p), .g(g), .out_valid(out_valid)
    );

    // Two combinational cells chained carry-to-carry.
    logic rst_c = 1'b0;
    logic iv_c = 1'b1;
    logic a0 = 1'b0, a1 = 1'b0, b0 = 1'b0, b1 = 1'b0, cin = 1'b0;
    logic l0, h0, p0, g0, ov0;
    logic l1, h1, p1, g1, ov1;

    gate_level_full_adder #(.REGISTER_OUT(1'b0)) u_bit0 (
        .clk(clk), .rst(rst_c), .in_valid(iv_c),
        .a(a0), .b(b0), .c(cin),
        .l(l0), .h(h0), .p(p0), .g(g0), .out_valid(ov0)
    );

    gate_level_full_adder #(.REGISTER_OUT(1'b0)) u_bit1 (
        .clk(clk), .rst(rst_c), .in_valid(iv_c),
        .a(a1), .b(b1), .c(h0),
        .l(l1), .h(h1), .p(p1), .g(g1), .out_valid(ov1)
    );

    // Reference state of the registered cell: {out_valid, h, l, p, g}.
    logic [4:0] model_q = 5'b0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_v;
    logic [4:0] obs_v;

    // Drive one cycle of stimulus, queue its expected result, then check after the edge.
    task automatic step(input logic r, input logic iv, input logic [2:0] abc, input string tag);
        int sum;
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        {a, b, c} = abc;
        sum = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
        if (r) begin
            model_q = 5'b0;
        end else begin
            model_q[4] = iv;
            if (iv) begin
                model_q[3] = (sum >= 2);
                model_q[2] = (sum % 2) == 1;
                model_q[1] = abc[2] | abc[1];
                model_q[0] = abc[2] & abc[1];
            end
        end
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, {out_valid, h, l, p, g});
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {out_valid, h, l, p, g};
            checks++;
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s: {ov,h,l,p,g} observed %b expected %b", tag, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        logic [4:0] vec;
        logic [2:0] exp_sum;
        logic [2:0] obs_sum;

        // Reset with a valid input present: the input is dropped.
        step(1'b1, 1'b1, 3'b111, "reset0");
        step(1'b1, 1'b1, 3'b111, "reset1");

        // All eight input combinations, one per cycle.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'(i), $sformatf("exh_%0d", i));
        end

        // Propagate and generate cases.
        step(1'b0, 1'b1, 3'b100, "pg_10");
        step(1'b0, 1'b1, 3'b110, "pg_11");
        step(1'b0, 1'b1, 3'b000, "pg_00");

        // Hold: the result of 111 stays when in_valid drops.
        step(1'b0, 1'b1, 3'b111, "hold_load");
        step(1'b0, 1'b0, 3'b000, "hold_0");
        step(1'b0, 1'b0, 3'b010, "hold_1");

        // Mid-stream reset, then release.
        step(1'b0, 1'b1, 3'b111, "mid_pre");
        step(1'b1, 1'b1, 3'b111, "mid_rst");
        step(1'b0, 1'b1, 3'b111, "mid_rel");

        // Back-to-back alternation of 110 and 001.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0) ? 3'b110 : 3'b001, $sformatf("b2b_%0d", i));
        end
        step(1'b0, 1'b0, 3'b000, "idle");

        // Two-bit ripple chain across all 32 input combinations.
        rst_c = 1'b0;
        iv_c  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            vec = 5'(i);
            {a1, a0, b1, b0, cin} = vec;
            #1;
            exp_sum = 3'(int'({a1, a0}) + int'({b1, b0}) + int'(cin));
            obs_sum = {h1, l1, l0};
            checks++;
            assert (obs_sum === exp_sum) else begin
                errors++;
                $error("FAIL ripple_%0d: sum observed %0d expected %0d", i, obs_sum, exp_sum);
            end
            checks++;
            assert ({p0, g0} === {a0 | b0, a0 & b0}) else begin
                errors++;
                $error("FAIL ripple_pg_%0d: {p,g} observed %b expected %b", i, {p0, g0}, {a0 | b0, a0 & b0});
            end
        end

        // In the combinational form, out_valid = in_valid & ~rst.
        for (int i = 0; i < 4; i++) begin
            {iv_c, rst_c} = 2'(i);
            #1;
            checks++;
            assert (ov0 === (iv_c & ~rst_c)) else begin
                errors++;
                $error("FAIL comb_ov_%0d: observed %b expected %b", i, ov0, iv_c & ~rst_c);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
